// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state encoding and default parameters for the SPI frame controller.
package spi_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, END} state_e;
  localparam int DEF_BIT_LENGTH = 20;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD = 2;
endpackage

// File: rtl/spi_phase_div.sv
// spi_phase_div: loadable down-counter flagging the final cycle of a phase.
module spi_phase_div #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         phase_last_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign phase_last_o = cnt_q == W'(1);
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: SPI mode-0 LSB-first master sequencing an external shift register.
// Define SPI_CS_HOLD_EN to keep cs_n low for CS_HOLD extra cycles after the last sclk fall.
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int BIT_LENGTH = DEF_BIT_LENGTH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int CS_SETUP   = DEF_CS_SETUP,
  parameter int CS_HOLD    = DEF_CS_HOLD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [BIT_LENGTH-1:0] rx_data,
  input  logic [BIT_LENGTH-1:0] sr_q,
  output logic                  sr_load_en,
  output logic                  sr_shift_en,
  output logic                  sr_serial_in,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);
  localparam int DW = $clog2(CLK_DIV + CS_HOLD + 1);
  localparam int CW = $clog2(BIT_LENGTH + 1);
`ifdef SPI_CS_HOLD_EN
  localparam int END_LEN = CLK_DIV + CS_HOLD;
`else
  localparam int END_LEN = CLK_DIV;
`endif
  state_e                state_q;
  logic [CW-1:0]         bit_cnt_q;
  logic                  miso_q, busy_q, done_q, cs_n_q, sclk_q;
  logic [BIT_LENGTH-1:0] rx_data_q;
  logic                  phase_last, last_bit, div_load;
  logic [DW-1:0]         div_val;
  assign last_bit = bit_cnt_q == CW'(BIT_LENGTH - 1);
  // Reload the divider on every state entry with the length of the phase being entered.
  assign div_load = (state_q == IDLE) ? start : (state_q != END) && phase_last;
  assign div_val = (state_q == IDLE) ? DW'(CS_SETUP) :
                   (state_q == HIGH && last_bit) ? DW'(END_LEN) : DW'(CLK_DIV);
  spi_phase_div #(.W(DW)) u_div (
    .clk          (clk),
    .reset        (reset),
    .load_i       (div_load),
    .load_val_i   (div_val),
    .phase_last_o (phase_last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= SETUP;
          bit_cnt_q <= '0;
          cs_n_q    <= 1'b0;
          busy_q    <= 1'b1;
        end
        SETUP, LOW: if (phase_last) begin
          state_q <= HIGH;
          sclk_q  <= 1'b1;
          miso_q  <= miso;
        end
        HIGH: if (phase_last) begin
          state_q   <= last_bit ? END : LOW;
          sclk_q    <= 1'b0;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        END: if (phase_last) begin
          state_q   <= IDLE;
          cs_n_q    <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          rx_data_q <= sr_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sr_load_en   = !reset && state_q == IDLE && start;
  assign sr_shift_en  = !reset && state_q == HIGH && phase_last;
  assign sr_serial_in = miso_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign rx_data      = rx_data_q;
  assign mosi         = !cs_n_q && sr_q[0];
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed bench with a shift-register model around two controller instances.
module tb_spi_frame_ctrl;
  localparam int BL = 20;
`ifdef SPI_CS_HOLD_EN
  localparam int HOLD = 2;
  localparam int FHOLD = 3;
`else
  localparam int HOLD = 0;
  localparam int FHOLD = 0;
`endif
  localparam int FRAME  = 2 + 2 * BL * 4 + HOLD;
  localparam int FFRAME = 2 + 2 * BL + FHOLD;
  logic clk = 0, reset = 1, start = 0, loop = 0, miso_v = 0, start_f = 0;
  logic busy, done, sr_load_en, sr_shift_en, sr_serial_in, sclk, cs_n, mosi, miso;
  logic busy_f, done_f, ld_f, sh_f, si_f, sclk_f, cs_n_f, mosi_f;
  logic [BL-1:0] rx_data, rx_f, sr = '0, sr_f = '0, tx = '0;
  logic sclk_p = 0, sclk_fp = 0;
  int checks = 0, failures = 0;
  int shifts = 0, loads = 0, dones = 0, rises = 0, mosi_ones = 0, rises_f = 0;
  always #5 clk = ~clk;
  assign miso = loop ? mosi : miso_v;
  spi_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .rx_data(rx_data),
    .sr_q(sr), .sr_load_en(sr_load_en), .sr_shift_en(sr_shift_en), .sr_serial_in(sr_serial_in),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );
  spi_frame_ctrl #(.CLK_DIV(1), .CS_HOLD(3)) dut_f (
    .clk(clk), .reset(reset), .start(start_f), .busy(busy_f), .done(done_f), .rx_data(rx_f),
    .sr_q(sr_f), .sr_load_en(ld_f), .sr_shift_en(sh_f), .sr_serial_in(si_f),
    .sclk(sclk_f), .cs_n(cs_n_f), .mosi(mosi_f), .miso(mosi_f)
  );
  always @(posedge clk) begin
    if (sr_load_en) sr <= tx;
    else if (sr_shift_en) sr <= {sr_serial_in, sr[BL-1:1]};
    if (ld_f) sr_f <= tx;
    else if (sh_f) sr_f <= {si_f, sr_f[BL-1:1]};
    sclk_p  <= sclk;
    sclk_fp <= sclk_f;
    if (sr_shift_en) shifts <= shifts + 1;
    if (sr_load_en) loads <= loads + 1;
    if (done) dones <= dones + 1;
    if (sclk && !sclk_p) rises <= rises + 1;
    if (sclk_f && !sclk_fp) rises_f <= rises_f + 1;
    if (sclk && mosi) mosi_ones <= mosi_ones + 1;
  end

  task automatic kick();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    start = 1;
    repeat (2) @(negedge clk);
    checks += 7;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    if (rx_data !== '0) begin failures++; $display("FAIL reset_rx got=%h exp=0", rx_data); end
    if (sr_load_en !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", sr_load_en); end
    if (sr_shift_en !== 1'b0) begin failures++; $display("FAIL reset_shift got=%b exp=0", sr_shift_en); end
    start = 0;
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    int n, s0, r0;
    loop = 1;
    tx = 20'hA5F0C;
    s0 = shifts;
    r0 = rises;
    kick();
    wait_done(n);
    checks += 5;
    if (n !== FRAME) begin failures++; $display("FAIL loop_latency got=%0d exp=%0d", n, FRAME); end
    if (rx_data !== 20'hA5F0C) begin failures++; $display("FAIL loop_rx got=%h exp=a5f0c", rx_data); end
    if (shifts - s0 !== 20) begin failures++; $display("FAIL loop_shifts got=%0d exp=20", shifts - s0); end
    if (rises - r0 !== 20) begin failures++; $display("FAIL loop_sclk_rises got=%0d exp=20", rises - r0); end
    if (busy !== 1'b0) begin failures++; $display("FAIL loop_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
  endtask

  task automatic test_miso_ones();
    int n, m0;
    loop = 0;
    miso_v = 1;
    tx = '0;
    m0 = mosi_ones;
    kick();
    wait_done(n);
    checks += 3;
    if (n !== FRAME) begin failures++; $display("FAIL ones_latency got=%0d exp=%0d", n, FRAME); end
    if (rx_data !== 20'hFFFFF) begin failures++; $display("FAIL ones_rx got=%h exp=fffff", rx_data); end
    if (mosi_ones - m0 !== 0) begin failures++; $display("FAIL ones_mosi_high got=%0d exp=0", mosi_ones - m0); end
    miso_v = 0;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int n, l0, d0;
    loop = 1;
    tx = 20'h3C5A1;
    l0 = loads;
    d0 = dones;
    kick();
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
      start = (n == 10 || n == 100);
    end
    start = 0;
    checks += 3;
    if (n !== FRAME) begin failures++; $display("FAIL ign_latency got=%0d exp=%0d", n, FRAME); end
    if (loads - l0 !== 1) begin failures++; $display("FAIL ign_loads got=%0d exp=1", loads - l0); end
    if (rx_data !== 20'h3C5A1) begin failures++; $display("FAIL ign_rx got=%h exp=3c5a1", rx_data); end
    repeat (20) @(negedge clk);
    checks++;
    if (dones - d0 !== 1) begin failures++; $display("FAIL ign_dones got=%0d exp=1", dones - d0); end
  endtask

  task automatic test_reset_mid();
    int n, d0;
    loop = 1;
    tx = 20'h12345;
    d0 = dones;
    kick();
    repeat (49) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    reset = 1;
    @(negedge clk);
    checks += 4;
    if (cs_n !== 1'b1) begin failures++; $display("FAIL mid_cs_n got=%b exp=1", cs_n); end
    if (sclk !== 1'b0) begin failures++; $display("FAIL mid_sclk got=%b exp=0", sclk); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
    reset = 0;
    repeat (200) @(negedge clk);
    checks++;
    if (dones !== d0) begin failures++; $display("FAIL mid_no_done got=%0d exp=%0d", dones, d0); end
    kick();
    wait_done(n);
    checks += 2;
    if (n !== FRAME) begin failures++; $display("FAIL mid_restart_latency got=%0d exp=%0d", n, FRAME); end
    if (rx_data !== 20'h12345) begin failures++; $display("FAIL mid_restart_rx got=%h exp=12345", rx_data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, csh;
    loop = 1;
    tx = 20'h0F0F5;
    @(negedge clk) start = 1;
    wait_done(n);
    n = 0;
    csh = 0;
    do begin
      @(negedge clk);
      n++;
      if (cs_n) csh++;
    end while (!done && n < 1000);
    start = 0;
    checks += 3;
    if (n !== FRAME + 1) begin failures++; $display("FAIL b2b_period got=%0d exp=%0d", n, FRAME + 1); end
    if (csh !== 1) begin failures++; $display("FAIL b2b_cs_high got=%0d exp=1", csh); end
    if (rx_data !== 20'h0F0F5) begin failures++; $display("FAIL b2b_rx got=%h exp=0f0f5", rx_data); end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_fast_div();
    int n, r0, csh;
    tx = 20'h6B2D9;
    r0 = rises_f;
    @(negedge clk) start_f = 1;
    @(negedge clk) start_f = 0;
    n = 0;
    csh = 0;
    while (!done_f && n < 1000) begin
      @(negedge clk);
      n++;
      if (cs_n_f && !done_f) csh++;
    end
    checks += 4;
    if (n !== FFRAME) begin failures++; $display("FAIL fast_latency got=%0d exp=%0d", n, FFRAME); end
    if (rx_f !== 20'h6B2D9) begin failures++; $display("FAIL fast_rx got=%h exp=6b2d9", rx_f); end
    if (rises_f - r0 !== 20) begin failures++; $display("FAIL fast_sclk_rises got=%0d exp=20", rises_f - r0); end
    if (csh !== 0) begin failures++; $display("FAIL fast_cs_gap got=%0d exp=0", csh); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_ones();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_fast_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

SPI master frame controller for the SPI ALU link. Sequences an external BIT_LENGTH-bit right-shifting frame register (parallel load, serial-in at MSB, serial-out at Q[0]) through one full-duplex, LSB-first SPI mode-0 transfer. Generates `sclk` and `cs_n`, and drives the register's load/shift controls. Exposes a start/busy/done handshake to the command logic and returns the received frame in `rx_data`.

## Interface
- BIT_LENGTH, 20, frame width in bits (≥2)
- CLK_DIV, 4, `sclk` half-period in `clk` cycles (≥1)
- CS_SETUP, 2, cycles with `cs_n` low before the first `sclk` rise (≥1)
- CS_HOLD, 2, extra `cs_n`-low cycles after the last `sclk` fall (used only with SPI_CS_HOLD_EN)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a transfer; accepted only in IDLE
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse; `rx_data` valid
- rx_data  out  BIT_LENGTH  received frame, held until next done
- sr_q  in  BIT_LENGTH  frame register contents
- sr_load_en  out  1  frame register load strobe (integrator wires `tx_data` to the register's parallel input)
- sr_shift_en  out  1  frame register shift strobe
- sr_serial_in  out  1  bit shifted into register MSB
- sclk  out  1  SPI clock, idle low
- cs_n  out  1  chip select, active low
- mosi  out  1  `sr_q[0]` while `cs_n` is low, else 0
- miso  in  1  slave data

## Operation
- States: IDLE, SETUP, HIGH, LOW, END.
- IDLE:
  - `sr_load_en` = `start` (combinational, IDLE only).
  - On `start` → SETUP; `cs_n` <= 0; `busy` <= 1.
  - `start` outside IDLE is ignored, with no load.
- SETUP: CS_SETUP cycles, `sclk` low, bit 0 already on `mosi` → HIGH.
- HIGH:
  - `sclk` = 1 for CLK_DIV cycles.
  - `miso_q` <= `miso` on the edge entering HIGH.
  - Last HIGH cycle: `sr_shift_en` = 1, `sr_serial_in` = `miso_q`; `bit_cnt` += 1.
  - → LOW if `bit_cnt` < BIT_LENGTH after increment, else → END.
- LOW: `sclk` = 0 for CLK_DIV cycles → HIGH.
- END:
  - `sclk` = 0 for CLK_DIV cycles (CLK_DIV + CS_HOLD with macro) → IDLE.
  - On that transition: `cs_n` <= 1, `busy` <= 0, `done` <= 1, `rx_data` <= `sr_q`.
- `sr_shift_en` pulses exactly BIT_LENGTH times per frame. First received bit ends up in `rx_data[0]`.
- `bit_cnt` width: $clog2(BIT_LENGTH+1). Divider counter width: $clog2(CLK_DIV+CS_HOLD+1). Neither counter wraps within a frame.
- Reset values: IDLE, `busy`=0, `done`=0, `cs_n`=1, `sclk`=0, `rx_data`=0, counters 0, `miso_q`=0. `sr_load_en`/`sr_shift_en` are 0 while `reset` is high.
- Reset mid-frame:
  - Abort on the next edge; outputs return to reset values; no `done`.
  - Frame register contents are left to its own reset.

## Timing
- `start` sampled at edge E0: load at E0; `cs_n` low from E0.
- First `sclk` rise at E0+CS_SETUP.
- Bit k falls at E0+CS_SETUP+(2k+1)·CLK_DIV.
- `done` high in the cycle after edge E0+CS_SETUP+2·BIT_LENGTH·CLK_DIV (+CS_HOLD with macro). Defaults: 162 cycles.
- `busy` falls on the same edge `done` rises.
- `start` in the `done` cycle is accepted (back-to-back). `cs_n` is then high for exactly one cycle.
- `mosi` changes with `sclk` fall; `miso` is sampled at `sclk` rise (mode 0).

## Configuration
- SPI_CS_HOLD_EN defined: END lasts CLK_DIV+CS_HOLD cycles; `cs_n` stays low through the hold.
- SPI_CS_HOLD_EN undefined: END lasts CLK_DIV cycles; CS_HOLD is unused.

## Structure
- Package `spi_ctrl_pkg`: state enum (IDLE, SETUP, HIGH, LOW, END), default BIT_LENGTH/CLK_DIV/CS_SETUP/CS_HOLD constants.
- Sub-module `spi_phase_div`:
  - Loadable down-counter; emits `phase_last` on the final cycle of each phase.
  - Loaded with CS_SETUP, CLK_DIV or CLK_DIV(+CS_HOLD) on state entry.

## Test plan
- Loopback (`miso`=`mosi`), frame register preloaded with 20'hA5F0C, defaults → `rx_data`=20'hA5F0C; `done` exactly 162 cycles after `start`; 20 `sr_shift_en` pulses; 20 `sclk` rises.
- `miso` tied 1, `tx`=20'h00000 → `mosi` 0 throughout; `rx_data`=20'hFFFFF.
- `start` re-asserted at cycles 10 and 100 of a frame → no extra `sr_load_en`; single `done`; frame timing unchanged.
- `reset` at cycle 50 → next cycle `cs_n`=1, `sclk`=0, `busy`=0; no `done`; new `start` completes normally.
- `start` held high continuously → back-to-back frames; `cs_n` high exactly 1 cycle between frames; `done` every 163 cycles.
- CLK_DIV=1, SPI_CS_HOLD_EN defined, CS_HOLD=3 → `sclk` = `clk`/2; `done` at 2+40+3 = 45 cycles; `cs_n` low through hold.
